branch_resolution_unit: RTL and testbench

BRANCH_RESOLUTION_UNIT -- requirements
Module: branch_resolution_unit

---
 rtl/branch_resolution_unit_pkg.sv | 19 +
 rtl/branch_outcome_decode.sv | 23 ++
 rtl/branch_resolution_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolution_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolution_unit_pkg.sv
// Shared constants for the branch resolution unit: funct3 branch encodings
// and the predictor counter reset value.
package branch_resolution_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned MAX_CTR_BITS = 4;

  // Weakly-not-taken is the value just below the taken threshold: 2^(n-1)-1.
  function automatic logic [MAX_CTR_BITS-1:0] weakly_not_taken(input int unsigned ctr_bits);
    return (4'd1 << (ctr_bits - 32'd1)) - 4'd1;
  endfunction

endpackage

// File: rtl/branch_outcome_decode.sv
// Decodes the actual branch outcome from funct3 and the ALU zero flag;
// funct3 codes 010/011 are not branches and are flagged illegal.
module branch_outcome_decode
  import branch_resolution_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       result_equal_zero,
  output logic       taken,
  output logic       illegal
);

  // Outcome decode: the ALU zero flag means "condition false" for EQ/LT/LTU.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ, F3_BLT, F3_BLTU: taken = ~result_equal_zero;
      F3_BNE, F3_BGE, F3_BGEU: taken = result_equal_zero;
      default:                 illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution with a bimodal saturating-counter predictor table and
// saturating resolve/mispredict statistics; all outputs are registered.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int STAT_BITS   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 predict_valid,
  input  logic [XLEN-1:0]      predict_pc,
  output logic                 predict_taken,
  output logic                 predict_ready,
  input  logic                 resolve_valid,
  input  logic [XLEN-1:0]      resolve_pc,
  input  logic [2:0]           inst_funct3,
  input  logic                 result_equal_zero,
  input  logic                 resolve_pred_taken,
  output logic                 take_branch,
  output logic                 mispredict,
  output logic                 illegal_branch,
  output logic                 resolve_done,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam logic [MAX_CTR_BITS-1:0] WNT_FULL = weakly_not_taken(CTR_BITS);
  localparam logic [CTR_BITS-1:0]  CTR_WNT   = WNT_FULL[CTR_BITS-1:0];
  localparam logic [CTR_BITS-1:0]  CTR_MAX   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]  CTR_ZERO  = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]  CTR_ONE   = CTR_BITS'(1'b1);
  localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};
  localparam logic [STAT_BITS-1:0] STAT_ZERO = {STAT_BITS{1'b0}};
  localparam logic [STAT_BITS-1:0] STAT_ONE  = STAT_BITS'(1'b1);

  logic [CTR_BITS-1:0]  bht_r [BHT_ENTRIES];
  logic [IDX_BITS-1:0]  pred_idx_s;
  logic [IDX_BITS-1:0]  res_idx_s;
  logic                 taken_s;
  logic                 illegal_s;
  logic                 res_legal_s;
  logic [CTR_BITS-1:0]  ctr_old_s;
  logic [CTR_BITS-1:0]  ctr_next_s;
  logic                 predict_taken_r;
  logic                 predict_ready_r;
  logic                 take_branch_r;
  logic                 mispredict_r;
  logic                 illegal_r;
  logic                 resolve_done_r;
  logic [STAT_BITS-1:0] branch_count_r;
  logic [STAT_BITS-1:0] mispredict_count_r;
  logic                 unused_pc_bits_s;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign pred_idx_s       = predict_pc[IDX_BITS+1:2];
  assign res_idx_s        = resolve_pc[IDX_BITS+1:2];
  assign unused_pc_bits_s = ^{predict_pc, resolve_pc};

  branch_outcome_decode u_decode (
    .funct3            (inst_funct3),
    .result_equal_zero (result_equal_zero),
    .taken             (taken_s),
    .illegal           (illegal_s)
  );

  assign res_legal_s = resolve_valid & ~illegal_s;
  assign ctr_old_s   = bht_r[res_idx_s];

  // Saturating counter step toward the resolved direction.
  always_comb begin
    ctr_next_s = ctr_old_s;
    if (taken_s) begin
      if (ctr_old_s != CTR_MAX) ctr_next_s = ctr_old_s + CTR_ONE;
      else                      ctr_next_s = ctr_old_s;
    end else begin
      if (ctr_old_s != CTR_ZERO) ctr_next_s = ctr_old_s - CTR_ONE;
      else                       ctr_next_s = ctr_old_s;
    end
  end

  // Predictor table: reset to weakly-not-taken, trained by legal resolves.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_r[i] <= CTR_WNT;
    end else if (res_legal_s) begin
      bht_r[res_idx_s] <= ctr_next_s;
    end
  end

  // Output registers; the lookup samples the table before this edge's update.
  always_ff @(posedge clock) begin
    if (reset) begin
      predict_ready_r <= 1'b0;
      predict_taken_r <= 1'b0;
      resolve_done_r  <= 1'b0;
      take_branch_r   <= 1'b0;
      mispredict_r    <= 1'b0;
      illegal_r       <= 1'b0;
    end else begin
      predict_ready_r <= predict_valid;
      predict_taken_r <= predict_valid & bht_r[pred_idx_s][CTR_BITS-1];
      resolve_done_r  <= resolve_valid;
      take_branch_r   <= res_legal_s & taken_s;
      mispredict_r    <= res_legal_s & (taken_s ^ resolve_pred_taken);
      illegal_r       <= resolve_valid & illegal_s;
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      branch_count_r     <= STAT_ZERO;
      mispredict_count_r <= STAT_ZERO;
    end else begin
      if (res_legal_s && branch_count_r != STAT_MAX)
        branch_count_r <= branch_count_r + STAT_ONE;
      if (res_legal_s && (taken_s ^ resolve_pred_taken) && mispredict_count_r != STAT_MAX)
        mispredict_count_r <= mispredict_count_r + STAT_ONE;
    end
  end

  assign predict_taken    = predict_taken_r;
  assign predict_ready    = predict_ready_r;
  assign take_branch      = take_branch_r;
  assign mispredict       = mispredict_r;
  assign illegal_branch   = illegal_r;
  assign resolve_done     = resolve_done_r;
  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit: hand-computed expectations for
// prediction, training, saturation, illegal funct3, aliasing and reset.
module tb_branch_resolution_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        predict_valid;
  logic [31:0] predict_pc;
  logic        predict_taken;
  logic        predict_ready;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [2:0]  inst_funct3;
  logic        result_equal_zero;
  logic        resolve_pred_taken;
  logic        take_branch;
  logic        mispredict;
  logic        illegal_branch;
  logic        resolve_done;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  branch_resolution_unit dut (
    .clock              (clock),
    .reset              (reset),
    .predict_valid      (predict_valid),
    .predict_pc         (predict_pc),
    .predict_taken      (predict_taken),
    .predict_ready      (predict_ready),
    .resolve_valid      (resolve_valid),
    .resolve_pc         (resolve_pc),
    .inst_funct3        (inst_funct3),
    .result_equal_zero  (result_equal_zero),
    .resolve_pred_taken (resolve_pred_taken),
    .take_branch        (take_branch),
    .mispredict         (mispredict),
    .illegal_branch     (illegal_branch),
    .resolve_done       (resolve_done),
    .branch_count       (branch_count),
    .mispredict_count   (mispredict_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    predict_valid      = 1'b0;
    predict_pc         = 32'h0;
    resolve_valid      = 1'b0;
    resolve_pc         = 32'h0;
    inst_funct3        = 3'b000;
    result_equal_zero  = 1'b0;
    resolve_pred_taken = 1'b0;
  endtask

  task automatic set_resolve(input logic [31:0] pc, input logic [2:0] f3,
                             input logic rez, input logic pt);
    resolve_valid      = 1'b1;
    resolve_pc         = pc;
    inst_funct3        = f3;
    result_equal_zero  = rez;
    resolve_pred_taken = pt;
  endtask

  task automatic set_predict(input logic [31:0] pc);
    predict_valid = 1'b1;
    predict_pc    = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    set_predict(32'h100);
    set_resolve(32'h100, 3'b000, 1'b0, 1'b0);
    tick(); tick();
    total++; if ({predict_ready, predict_taken} !== 2'b00) begin bad++;
      $display("FAIL reset_predict got=%b want=00", {predict_ready, predict_taken}); end
    total++; if ({resolve_done, take_branch, mispredict, illegal_branch} !== 4'b0000) begin bad++;
      $display("FAIL reset_resolve got=%b want=0000", {resolve_done, take_branch, mispredict, illegal_branch}); end
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin bad++;
      $display("FAIL reset_stats got=%0d/%0d want=0/0", branch_count, mispredict_count); end
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_predict_after_reset();
    set_predict(32'h100);
    tick();
    total++; if ({predict_ready, predict_taken} !== 2'b10) begin bad++;
      $display("FAIL first_predict got=%b want=10", {predict_ready, predict_taken}); end
    idle();
    tick();
    total++; if ({predict_ready, predict_taken} !== 2'b00) begin bad++;
      $display("FAIL predict_idle got=%b want=00", {predict_ready, predict_taken}); end
  endtask

  // Two back-to-back taken BEQs at 0x100: 01 -> 10 -> 11; one not-taken -> 10.
  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      set_resolve(32'h100, 3'b000, 1'b0, 1'b0);
      tick();
      total++; if ({resolve_done, take_branch, mispredict, illegal_branch} !== 4'b1110) begin bad++;
        $display("FAIL b2b_resolve%0d got=%b want=1110", i, {resolve_done, take_branch, mispredict, illegal_branch}); end
    end
    idle();
    set_predict(32'h100);
    tick();
    total++; if ({resolve_done, take_branch, mispredict} !== 3'b000) begin bad++;
      $display("FAIL b2b_done_clear got=%b want=000", {resolve_done, take_branch, mispredict}); end
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL b2b_predict got=%b want=1", predict_taken); end
    total++; if (branch_count !== 32'd2) begin bad++;
      $display("FAIL b2b_branch_count got=%0d want=2", branch_count); end
    idle();
    set_resolve(32'h100, 3'b001, 1'b0, 1'b1);
    tick();
    total++; if ({take_branch, mispredict} !== 2'b01) begin bad++;
      $display("FAIL b2b_nt_resolve got=%b want=01", {take_branch, mispredict}); end
    idle();
    set_predict(32'h100);
    tick();
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL b2b_both_applied got=%b want=1", predict_taken); end
    total++; if (branch_count !== 32'd3 || mispredict_count !== 32'd3) begin bad++;
      $display("FAIL b2b_stats got=%0d/%0d want=3/3", branch_count, mispredict_count); end
    idle();
  endtask

  // 0x104 goes 01 -> 00, then four more not-taken resolves must hold it at 00.
  task automatic test_saturate_low();
    logic [2:0] f3_tab [4];
    logic       rez_tab [4];
    logic       pt_tab [4];
    f3_tab  = '{3'b001, 3'b101, 3'b111, 3'b100};
    rez_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
    pt_tab  = '{1'b1, 1'b0, 1'b1, 1'b0};
    set_resolve(32'h104, 3'b000, 1'b1, 1'b0);
    tick();
    total++; if ({take_branch, mispredict} !== 2'b00) begin bad++;
      $display("FAIL sat_first got=%b want=00", {take_branch, mispredict}); end
    for (int i = 0; i < 4; i++) begin
      idle();
      set_resolve(32'h104, f3_tab[i], rez_tab[i], pt_tab[i]);
      tick();
      total++; if ({resolve_done, take_branch, mispredict} !== {1'b1, 1'b0, pt_tab[i]}) begin bad++;
        $display("FAIL sat_resolve%0d got=%b want=%b", i, {resolve_done, take_branch, mispredict}, {1'b1, 1'b0, pt_tab[i]}); end
      idle();
      set_predict(32'h104);
      tick();
      total++; if ({predict_ready, predict_taken} !== 2'b10) begin bad++;
        $display("FAIL sat_predict%0d got=%b want=10", i, {predict_ready, predict_taken}); end
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      set_resolve(32'h104, 3'b000, 1'b0, 1'b0);
      tick();
    end
    idle();
    set_predict(32'h104);
    tick();
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL sat_recover got=%b want=1", predict_taken); end
    total++; if (branch_count !== 32'd10 || mispredict_count !== 32'd7) begin bad++;
      $display("FAIL sat_stats got=%0d/%0d want=10/7", branch_count, mispredict_count); end
    idle();
  endtask

  task automatic test_same_cycle();
    set_predict(32'h108);
    set_resolve(32'h108, 3'b110, 1'b0, 1'b0);
    tick();
    total++; if ({predict_ready, predict_taken} !== 2'b10) begin bad++;
      $display("FAIL same_cycle_predict got=%b want=10", {predict_ready, predict_taken}); end
    total++; if ({take_branch, mispredict} !== 2'b11) begin bad++;
      $display("FAIL same_cycle_resolve got=%b want=11", {take_branch, mispredict}); end
    idle();
    set_predict(32'h108);
    tick();
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL same_cycle_next got=%b want=1", predict_taken); end
    idle();
  endtask

  task automatic test_illegal();
    set_resolve(32'h108, 3'b010, 1'b1, 1'b1);
    tick();
    total++; if ({resolve_done, take_branch, mispredict, illegal_branch} !== 4'b1001) begin bad++;
      $display("FAIL illegal_010 got=%b want=1001", {resolve_done, take_branch, mispredict, illegal_branch}); end
    set_resolve(32'h108, 3'b011, 1'b1, 1'b0);
    tick();
    total++; if ({resolve_done, take_branch, mispredict, illegal_branch} !== 4'b1001) begin bad++;
      $display("FAIL illegal_011 got=%b want=1001", {resolve_done, take_branch, mispredict, illegal_branch}); end
    idle();
    set_predict(32'h108);
    tick();
    total++; if (illegal_branch !== 1'b0) begin bad++;
      $display("FAIL illegal_clear got=%b want=0", illegal_branch); end
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL illegal_ctr_kept got=%b want=1", predict_taken); end
    total++; if (branch_count !== 32'd11 || mispredict_count !== 32'd8) begin bad++;
      $display("FAIL illegal_stats got=%0d/%0d want=11/8", branch_count, mispredict_count); end
    idle();
  endtask

  task automatic test_outcome_table();
    logic [2:0] f3_tab [6];
    logic       eq_like [6];
    logic       want;
    f3_tab  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    eq_like = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      for (int z = 0; z < 2; z++) begin
        want = eq_like[i] ? (z == 0) : (z == 1);
        set_resolve(32'h10C, f3_tab[i], z[0], 1'b0);
        tick();
        total++; if ({take_branch, mispredict, illegal_branch} !== {want, want, 1'b0}) begin bad++;
          $display("FAIL outcome_f3_%b_z%0d got=%b want=%b", f3_tab[i], z, {take_branch, mispredict, illegal_branch}, {want, want, 1'b0}); end
      end
    end
    idle();
    tick();
    total++; if (branch_count !== 32'd23 || mispredict_count !== 32'd14) begin bad++;
      $display("FAIL outcome_stats got=%0d/%0d want=23/14", branch_count, mispredict_count); end
  endtask

  // 0x200 aliases 0x100 (index 0, currently 10); reset mid-stream restores 01.
  task automatic test_alias_and_reset();
    set_predict(32'h200);
    tick();
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL alias_predict got=%b want=1", predict_taken); end
    set_predict(32'h200);
    set_resolve(32'h200, 3'b000, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    total++; if ({predict_ready, predict_taken, resolve_done, take_branch, mispredict, illegal_branch} !== 6'b000000) begin bad++;
      $display("FAIL midreset_outputs got=%b want=000000", {predict_ready, predict_taken, resolve_done, take_branch, mispredict, illegal_branch}); end
    total++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin bad++;
      $display("FAIL midreset_stats got=%0d/%0d want=0/0", branch_count, mispredict_count); end
    reset = 1'b0;
    idle();
    set_predict(32'h200);
    tick();
    total++; if ({predict_ready, predict_taken} !== 2'b10) begin bad++;
      $display("FAIL midreset_entry got=%b want=10", {predict_ready, predict_taken}); end
    idle();
    set_resolve(32'h100, 3'b000, 1'b0, 1'b1);
    tick();
    idle();
    set_predict(32'h200);
    tick();
    total++; if (predict_taken !== 1'b1) begin bad++;
      $display("FAIL midreset_was_01 got=%b want=1", predict_taken); end
    total++; if (branch_count !== 32'd1 || mispredict_count !== 32'd0) begin bad++;
      $display("FAIL midreset_restart got=%0d/%0d want=1/0", branch_count, mispredict_count); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_predict_after_reset();
    test_back_to_back();
    test_saturate_low();
    test_same_cycle();
    test_illegal();
    test_outcome_table();
    test_alias_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
